// File: rtl/ubuf_arbiter.sv
// Round-robin arbiter and sequencer for the unified buffer port.
// Optional per-transaction timeout abort is enabled by defining UBUF_ARB_TIMEOUT_EN.
module ubuf_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ADDRESS_SIZE   = 9,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TIMEOUT_WIDTH  = $clog2(TIMEOUT_CYCLES+1)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_REQ-1:0]                   req,
    input  logic [NUM_REQ-1:0]                   req_we,
    input  logic [NUM_REQ-1:0][1:0]              req_mode,
    input  logic [NUM_REQ-1:0]                   req_section,
    input  logic [NUM_REQ-1:0][ADDRESS_SIZE-1:0] req_addr,
    output logic [NUM_REQ-1:0]                   grant,
    output logic [NUM_REQ-1:0]                   req_done,
    output logic                                 req_err,
    output logic                                 buf_we,
    output logic                                 buf_re,
    output logic                                 buf_fifo_en,
    output logic                                 buf_compute_en,
    output logic                                 buf_store_en,
    output logic                                 buf_section,
    output logic [ADDRESS_SIZE-1:0]              buf_address,
    input  logic                                 buf_done,
    output logic                                 busy,
    output logic                                 timeout_flag,
    input  logic                                 clr_err
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACTIVE  = 2'd1;
    localparam logic [1:0] ABORT   = 2'd2;
    localparam logic [1:0] RELEASE = 2'd3;

    logic [1:0]       state;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] sel_idx;
    logic [PTR_W-1:0] cand;
    logic             sel_found;
    logic [1:0]       sel_mode;
    logic             to_hit;

    // Rotating search: first set request at or after ptr, wrapping.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = PTR_W'((int'(ptr) + i) % NUM_REQ);
            if (!sel_found && req[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    assign sel_mode = req_mode[sel_idx];
    assign busy     = (state != IDLE);

`ifdef UBUF_ARB_TIMEOUT_EN
    logic [TIMEOUT_WIDTH-1:0] tcnt;

    assign to_hit = (state == ACTIVE) && !buf_done &&
                    (tcnt == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tcnt <= '0;
        end else if (state == IDLE) begin
            tcnt <= '0;
        end else if (state == ACTIVE) begin
            tcnt <= tcnt + 1'b1;
        end
    end

    // A fresh timeout wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timeout_flag <= 1'b0;
        end else if (to_hit) begin
            timeout_flag <= 1'b1;
        end else if (clr_err) begin
            timeout_flag <= 1'b0;
        end
    end
`else
    logic unused_cfg;

    assign to_hit       = 1'b0;
    assign timeout_flag = 1'b0;
    assign unused_cfg   = clr_err | (TIMEOUT_CYCLES == 0) | (TIMEOUT_WIDTH == 0);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            ptr            <= '0;
            grant          <= '0;
            req_done       <= '0;
            req_err        <= 1'b0;
            buf_we         <= 1'b0;
            buf_re         <= 1'b0;
            buf_fifo_en    <= 1'b0;
            buf_compute_en <= 1'b0;
            buf_store_en   <= 1'b0;
            buf_section    <= 1'b0;
            buf_address    <= '0;
        end else begin
            req_done <= '0;
            req_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        grant       <= NUM_REQ'(1) << sel_idx;
                        ptr         <= (sel_idx == PTR_W'(NUM_REQ - 1)) ? '0 : sel_idx + 1'b1;
                        buf_section <= req_section[sel_idx];
                        buf_address <= req_addr[sel_idx];
                        if (sel_mode == 2'b11) begin
                            state <= ABORT;
                        end else begin
                            state          <= ACTIVE;
                            buf_we         <= req_we[sel_idx];
                            buf_re         <= ~req_we[sel_idx];
                            buf_fifo_en    <= (sel_mode == 2'b00);
                            buf_compute_en <= (sel_mode == 2'b01);
                            buf_store_en   <= (sel_mode == 2'b10);
                        end
                    end
                end
                ACTIVE: begin
                    if (buf_done || to_hit) begin
                        buf_we         <= 1'b0;
                        buf_re         <= 1'b0;
                        buf_fifo_en    <= 1'b0;
                        buf_compute_en <= 1'b0;
                        buf_store_en   <= 1'b0;
                    end
                    if (buf_done) begin
                        req_done <= grant;
                        state    <= RELEASE;
                    end else if (to_hit) begin
                        state <= ABORT;
                    end
                end
                ABORT: begin
                    req_done <= grant;
                    req_err  <= 1'b1;
                    state    <= RELEASE;
                end
                default: begin
                    grant <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
